// File: rtl/config_sequencer.sv
// config_sequencer: replays a host-loaded table of (configId, chainId, configData)
// entries onto the instrumentation reconfiguration interface. Before tracing is
// dropped it stalls upstream for a fixed drain period so no traced vector is in
// flight while the downstream units rewrite their config bytes.
module config_sequencer #(
    parameter int unsigned TABLE_DEPTH  = 16,
    parameter int unsigned MAX_CHAINS   = 4,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter logic [7:0]  IDLE_ID      = 8'hFF,
    localparam int unsigned CHAIN_W     = $clog2(MAX_CHAINS),
    localparam int unsigned AW          = $clog2(TABLE_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [7:0]         wr_config_id,
    input  logic [CHAIN_W-1:0] wr_chain_id,
    input  logic [7:0]         wr_data,
    input  logic [AW:0]        num_entries,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               hold_upstream,
    output logic               tracing,
    output logic [7:0]         configId,
    output logic [7:0]         configData,
    output logic [CHAIN_W-1:0] chainId
);

    localparam int unsigned NW = AW + 1;
    localparam int unsigned DW = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [NW-1:0] DEPTH_N    = NW'(TABLE_DEPTH);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_DRAIN      = 3'd1;
    localparam logic [2:0] S_GUARD_PRE  = 3'd2;
    localparam logic [2:0] S_CONFIG     = 3'd3;
    localparam logic [2:0] S_GUARD_POST = 3'd4;

    logic [2:0]    state;
    logic [NW-1:0] n_q;
    logic [NW-1:0] idx;
    logic [DW-1:0] drain_cnt;
    logic [AW-1:0] rd_addr;
    logic [NW-1:0] n_clamped;
    logic          wr_ok;

    logic [7:0]         tbl_id    [TABLE_DEPTH];
    logic [CHAIN_W-1:0] tbl_chain [TABLE_DEPTH];
    logic [7:0]         tbl_data  [TABLE_DEPTH];

    // Write qualification, entry count clamp and table read index
    always_comb begin
        wr_ok     = wr_en && !busy && (NW'(wr_addr) < DEPTH_N);
        n_clamped = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
        rd_addr   = idx[AW-1:0];
    end

    // Config table storage; deliberately not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            tbl_id[wr_addr]    <= wr_config_id;
            tbl_chain[wr_addr] <= wr_chain_id;
            tbl_data[wr_addr]  <= wr_data;
        end
    end

    // Sequencer FSM; outputs are registered from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            n_q           <= '0;
            idx           <= '0;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            hold_upstream <= 1'b0;
            tracing       <= 1'b1;
            configId      <= IDLE_ID;
            configData    <= '0;
            chainId       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        n_q           <= n_clamped;
                        idx           <= '0;
                        drain_cnt     <= '0;
                        busy          <= 1'b1;
                        hold_upstream <= 1'b1;
                        state         <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        tracing  <= 1'b0;
                        configId <= IDLE_ID;
                        state    <= S_GUARD_PRE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_GUARD_PRE: begin
                    if (n_q != '0) begin
                        configId   <= tbl_id[rd_addr];
                        chainId    <= tbl_chain[rd_addr];
                        configData <= tbl_data[rd_addr];
                        idx        <= idx + 1'b1;
                        state      <= S_CONFIG;
                    end else begin
                        state <= S_GUARD_POST;
                    end
                end
                S_CONFIG: begin
                    // idx already points one past the entry currently on the bus
                    if (idx == n_q) begin
                        configId   <= IDLE_ID;
                        chainId    <= '0;
                        configData <= '0;
                        state      <= S_GUARD_POST;
                    end else begin
                        configId   <= tbl_id[rd_addr];
                        chainId    <= tbl_chain[rd_addr];
                        configData <= tbl_data[rd_addr];
                        idx        <= idx + 1'b1;
                    end
                end
                S_GUARD_POST: begin
                    tracing       <= 1'b1;
                    hold_upstream <= 1'b0;
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    state         <= S_IDLE;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    hold_upstream <= 1'b0;
                    tracing       <= 1'b1;
                    configId      <= IDLE_ID;
                    configData    <= '0;
                    chainId       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_sequencer.sv
// tb_config_sequencer: directed bench for config_sequencer with hand-computed
// expectations, plus a tiny reduce-unit model fed from the config interface.
module tb_config_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_config_id;
    logic [1:0] wr_chain_id;
    logic [7:0] wr_data;
    logic [4:0] num_entries;
    logic       start;
    logic       busy, done, hold_upstream, tracing;
    logic [7:0] configId, configData;
    logic [1:0] chainId;

    int checks = 0;
    int errors = 0;

    // intended table contents as loaded by the bench
    logic [7:0] exp_id   [16];
    logic [1:0] exp_ch   [16];
    logic [7:0] exp_dat  [16];

    // capture of one pass
    logic [7:0] cap_id  [32];
    logic [1:0] cap_ch  [32];
    logic [7:0] cap_dat [32];
    int low_cnt, hold_pre, done_cnt, cyc_done;

    // reduce unit model (unit id 0): per-chain mode byte, 1 = sum
    logic [7:0] red_mode [4];
    int         acc [4];

    config_sequencer #(
        .TABLE_DEPTH(16), .MAX_CHAINS(4), .DRAIN_CYCLES(8), .IDLE_ID(8'hFF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_config_id(wr_config_id), .wr_chain_id(wr_chain_id), .wr_data(wr_data),
        .num_entries(num_entries), .start(start), .busy(busy), .done(done),
        .hold_upstream(hold_upstream), .tracing(tracing), .configId(configId),
        .configData(configData), .chainId(chainId)
    );

    always #5 clk = ~clk;

    // reduce unit picks up config bytes addressed to it while tracing is low
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) red_mode[c] <= 8'h00;
        end else if (!tracing && configId == 8'h00) begin
            red_mode[chainId] <= configData;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [7:0] id,
                               input logic [1:0] ch, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_config_id = id; wr_chain_id = ch; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        exp_id[a] = id; exp_ch[a] = ch; exp_dat[a] = d;
    endtask

    // one pass; disturb adds a write and a start pulse while busy
    task automatic run_pass(input logic [4:0] n, input bit disturb);
        bit seen_low;
        low_cnt = 0; hold_pre = 0; done_cnt = 0; cyc_done = -1; seen_low = 0;
        @(negedge clk);
        num_entries = n; start = 1'b1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (disturb) begin
                if (cyc == 3) begin
                    wr_en = 1'b1; wr_addr = 4'd0; wr_config_id = 8'h55;
                    wr_chain_id = 2'd2; wr_data = 8'hAA;
                end
                if (cyc == 4)  wr_en = 1'b0;
                if (cyc == 11) start = 1'b1;
                if (cyc == 12) start = 1'b0;
            end
            if (!tracing) begin
                if (low_cnt < 32) begin
                    cap_id[low_cnt] = configId; cap_ch[low_cnt] = chainId;
                    cap_dat[low_cnt] = configData;
                end
                low_cnt++;
                seen_low = 1'b1;
            end else if (!seen_low && hold_upstream) begin
                hold_pre++;
            end
            if (done) begin
                done_cnt++;
                if (cyc_done < 0) begin
                    cyc_done = cyc;
                    check("done_tracing", 32'(tracing), 32'd1);
                    check("done_hold", 32'(hold_upstream), 32'd0);
                    check("done_busy", 32'(busy), 32'd0);
                end
            end
            if (cyc_done >= 0 && cyc >= cyc_done + (disturb ? 20 : 2)) break;
        end
        if (cyc_done < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_entries(input string tag, input int n);
        check({tag, "_lowlen"}, 32'(low_cnt), 32'(n + 2));
        if (low_cnt == n + 2) begin
            check({tag, "_pre_id"}, 32'(cap_id[0]), 32'hFF);
            check({tag, "_post_id"}, 32'(cap_id[n + 1]), 32'hFF);
            for (int k = 0; k < n; k++) begin
                check($sformatf("%s_e%0d", tag, k),
                      {8'h0, cap_id[k + 1], 6'h0, cap_ch[k + 1], cap_dat[k + 1]},
                      {8'h0, exp_id[k], 6'h0, exp_ch[k], exp_dat[k]});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_config_id = '0;
        wr_chain_id = '0; wr_data = '0; num_entries = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tracing", 32'(tracing), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hold", 32'(hold_upstream), 32'd0);
        check("rst_id", 32'(configId), 32'hFF);
        check("rst_data", 32'(configData), 32'd0);
        check("rst_chain", 32'(chainId), 32'd0);
        rst_n = 1'b1;

        // basic 3-entry pass
        write_entry(4'd0, 8'h00, 2'd0, 8'h01);
        write_entry(4'd1, 8'h01, 2'd1, 8'h01);
        write_entry(4'd2, 8'h02, 2'd3, 8'h00);
        run_pass(5'd3, 1'b0);
        check("p3_hold_pre", 32'(hold_pre), 32'd8);
        check_entries("p3", 3);
        check("p3_done_cyc", 32'(cyc_done), 32'd14);
        check("p3_done_cnt", 32'(done_cnt), 32'd1);

        // reduce unit chain 0 set to sum; trace 1..8
        check("red_mode0", 32'(red_mode[0]), 32'd1);
        for (int c = 0; c < 4; c++) acc[c] = 0;
        for (int v = 1; v <= 8; v++) begin
            @(negedge clk);
            check($sformatf("red_tracing_%0d", v), 32'(tracing), 32'd1);
            for (int c = 0; c < 4; c++) if (red_mode[c] == 8'd1) acc[c] += v;
        end
        check("red_out0", 32'(acc[0]), 32'd36);
        check("red_out1", 32'(acc[1]), 32'd0);
        check("red_out2", 32'(acc[2]), 32'd0);
        check("red_out3", 32'(acc[3]), 32'd0);

        // empty pass
        run_pass(5'd0, 1'b0);
        check_entries("p0", 0);
        check("p0_done_cyc", 32'(cyc_done), 32'd11);

        // start and write while busy are both ignored
        run_pass(5'd3, 1'b1);
        check("dist_done_cnt", 32'(done_cnt), 32'd1);
        check_entries("dist", 3);
        run_pass(5'd3, 1'b0);
        check_entries("after_dist", 3);

        // async reset during CONFIG entry 1
        @(negedge clk);
        num_entries = 5'd3; start = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
        end
        check("abort_entry1_id", 32'(configId), 32'h01);
        rst_n = 1'b0;
        #1;
        check("abort_tracing", 32'(tracing), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_id", 32'(configId), 32'hFF);
        check("abort_hold", 32'(hold_upstream), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_pass(5'd3, 1'b0);
        check_entries("replay", 3);

        // fill table to 16 entries, then request 20
        for (int a = 3; a < 16; a++)
            write_entry(4'(a), 8'(8'h10 + a), 2'(a), 8'(8'hC0 + a));
        run_pass(5'd20, 1'b0);
        check_entries("p20", 16);
        check("p20_done_cyc", 32'(cyc_done), 32'd27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
